// File: rtl/fetch_aligner.sv
// fetch_aligner: turns a stream of 32-bit icache words into aligned RV32C/RV32I
// instructions. It keeps up to three halfwords in a buffer, issues word fetches
// while there is room, and handles redirects, including a response that is still
// in flight when the redirect arrives.
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-low reset
//   rdy_in                 global enable; low freezes every register
//   flush_in, flush_pc_in  redirect request and its halfword-aligned target
//   mem_req_out            one-cycle fetch request (combinational in IDLE)
//   mem_addr_out           word address of the request
//   mem_valid_in           one-cycle response strobe, mem_data_in is the word
//   inst_valid_out         inst_out/pc_out/is_c_out describe a complete instruction
//   inst_ready_in          decoder takes the instruction this cycle
//   inst_out, pc_out       instruction (upper half zero when compressed) and its address
//   is_c_out               instruction is 16-bit
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_valid_in,
    input  logic [31:0] mem_data_in,
    output logic        inst_valid_out,
    input  logic        inst_ready_in,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        is_c_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned HW    = 16;
    localparam int unsigned BUF_W = 48;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d, buf_s, app;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_s;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   fetch_addr_q, fetch_addr_d;
    logic              skip_lo_q, skip_lo_d;
    logic              comp_q, avail_q, req_c;
    logic              comp_d, valid_d;
    logic [XLEN-1:0]   inst_d;

    // Decode of the current buffer head; drives the consume decision.
    assign comp_q  = (buf_q[1:0] != 2'b11);
    assign avail_q = comp_q ? (cnt_q != 2'd0) : (cnt_q >= 2'd2);

    // Next-state: flush wins, otherwise consume (shift) first, then append.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        skip_lo_d    = skip_lo_q;
        buf_s        = buf_q;
        cnt_s        = cnt_q;
        app          = '0;
        req_c        = 1'b0;

        if (rdy_in) begin
            if (flush_in) begin
                buf_d        = '0;
                cnt_d        = '0;
                pc_d         = flush_pc_in;
                fetch_addr_d = {flush_pc_in[31:2], 2'b00};
                skip_lo_d    = flush_pc_in[1];
                // A response landing in the flush cycle already closes the
                // outstanding request, so there is nothing left to drain.
                if (state_q != S_IDLE) begin
                    state_d = mem_valid_in ? S_IDLE : S_DRAIN;
                end
            end else begin
                if (avail_q && inst_ready_in) begin
                    if (comp_q) begin
                        buf_s = buf_q >> HW;
                        cnt_s = cnt_q - 2'd1;
                        pc_d  = pc_q + 32'd2;
                    end else begin
                        buf_s = buf_q >> (2 * HW);
                        cnt_s = cnt_q - 2'd2;
                        pc_d  = pc_q + 32'd4;
                    end
                end
                buf_d = buf_s;
                cnt_d = cnt_s;

                case (state_q)
                    S_IDLE: begin
                        if (cnt_q <= 2'd1) begin
                            req_c        = 1'b1;
                            fetch_addr_d = fetch_addr_q + 32'd4;
                            state_d      = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (mem_valid_in) begin
                            // Halfwords above cnt are always zero, so OR appends.
                            if (skip_lo_q) begin
                                app       = {32'h0, mem_data_in[31:16]};
                                cnt_d     = cnt_s + 2'd1;
                                skip_lo_d = 1'b0;
                            end else begin
                                app   = {16'h0, mem_data_in};
                                cnt_d = cnt_s + 2'd2;
                            end
                            buf_d   = buf_s | (app << {cnt_s, 4'b0000});
                            state_d = S_IDLE;
                        end
                    end
                    S_DRAIN: begin
                        if (mem_valid_in) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        comp_d  = (buf_d[1:0] != 2'b11);
        valid_d = comp_d ? (cnt_d != 2'd0) : (cnt_d >= 2'd2);
        inst_d  = '0;
        if (valid_d) begin
            inst_d = comp_d ? {16'h0, buf_d[15:0]} : buf_d[31:0];
        end
    end

    // Request is issued in the deciding cycle; held low while reset is asserted.
    assign mem_req_out  = req_c & rst_in;
    assign mem_addr_out = mem_req_out ? fetch_addr_q : '0;
    assign pc_out       = pc_q;

    // State and registered instruction outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= S_IDLE;
            buf_q          <= '0;
            cnt_q          <= '0;
            pc_q           <= RESET_PC;
            fetch_addr_q   <= {RESET_PC[31:2], 2'b00};
            skip_lo_q      <= RESET_PC[1];
            inst_valid_out <= 1'b0;
            inst_out       <= '0;
            is_c_out       <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            pc_q           <= pc_d;
            fetch_addr_q   <= fetch_addr_d;
            skip_lo_q      <= skip_lo_d;
            inst_valid_out <= valid_d;
            inst_out       <= inst_d;
            is_c_out       <= valid_d & comp_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Testbench for fetch_aligner: directed scenarios plus a randomized run checked
// against a program-walk model (instruction stream derived from a memory image).
module tb_fetch_aligner;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic [31:0] flush_pc_in = 32'h0;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_valid_in = 1'b0;
    logic [31:0] mem_data_in = 32'h0;
    logic        inst_valid_out;
    logic        inst_ready_in = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        is_c_out;

    fetch_aligner #(.RESET_PC(32'h0)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .flush_pc_in   (flush_pc_in),
        .mem_req_out   (mem_req_out),
        .mem_addr_out  (mem_addr_out),
        .mem_valid_in  (mem_valid_in),
        .mem_data_in   (mem_data_in),
        .inst_valid_out(inst_valid_out),
        .inst_ready_in (inst_ready_in),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .is_c_out      (is_c_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: one outstanding request, response after a delay.
    logic [31:0] mem_img [0:255];
    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;
    int          mem_delay = 1;
    logic        rand_delay = 1'b0;

    // What the DUT showed during the last stepped cycle.
    logic        obs_valid, obs_c, obs_req, obs_mvalid, obs_req_busy;
    logic [31:0] obs_inst, obs_pc, obs_addr;

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_img[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // One clock cycle: drive inputs, sample, clock, advance the memory model.
    task automatic step(input logic rdy, input logic fl, input logic [31:0] fpc, input logic rdyi);
        rdy_in        = rdy;
        flush_in      = fl;
        flush_pc_in   = fpc;
        inst_ready_in = rdyi;
        mem_valid_in  = pending && (pend_wait == 0) && rdy;
        mem_data_in   = mem_valid_in ? mem_img[pend_addr[9:2]] : 32'hDEAD_BEEF;
        #1;
        obs_valid    = inst_valid_out;
        obs_inst     = inst_out;
        obs_pc       = pc_out;
        obs_c        = is_c_out;
        obs_req      = mem_req_out;
        obs_addr     = mem_addr_out;
        obs_mvalid   = mem_valid_in;
        obs_req_busy = mem_req_out && pending;
        @(posedge clk_in);
        if (mem_valid_in) pending = 1'b0;
        else if (pending && pend_wait > 0 && rdy) pend_wait--;
        if (obs_req) begin
            pending   = 1'b1;
            pend_addr = obs_addr;
            pend_wait = (rand_delay ? int'($urandom_range(1, 3)) : mem_delay) - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        inst_ready_in = 1'b0;
        mem_valid_in  = 1'b0;
        pending       = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; inst_ready_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        n_tests++; if (mem_req_out !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req_out); end
        n_tests++; if (mem_addr_out !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr_out); end
        n_tests++; if (inst_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid_out); end
        n_tests++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst_out); end
        n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_out); end
        n_tests++; if (is_c_out !== 1'b0) begin n_fail++; $display("FAIL reset_isc got %b want 0", is_c_out); end
        rst_in = 1'b1;
    endtask

    task automatic test_single();
        mem_img[0] = 32'h00A00093; mem_img[1] = 32'h0000_0001; mem_delay = 1;
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_req !== 1'b1) begin n_fail++; $display("FAIL single_first_req got %b want 1", obs_req); end
        n_tests++; if (obs_addr !== 32'h0) begin n_fail++; $display("FAIL single_addr got %h want 0", obs_addr); end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", obs_valid); end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", obs_valid); end
        n_tests++; if (obs_inst !== 32'h00A00093) begin n_fail++; $display("FAIL single_inst got %h want 00a00093", obs_inst); end
        n_tests++; if (obs_pc !== 32'h0) begin n_fail++; $display("FAIL single_pc got %h want 0", obs_pc); end
        n_tests++; if (obs_c !== 1'b0) begin n_fail++; $display("FAIL single_isc got %b want 0", obs_c); end
    endtask

    task automatic test_compressed();
        mem_img[0] = 32'h45014581; mem_img[1] = 32'h0001_0001; mem_delay = 1;
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_valid !== 1'b1 || obs_inst !== 32'h00004581 || obs_pc !== 32'h0 || obs_c !== 1'b1) begin
            n_fail++; $display("FAIL comp_first got v=%b %h @%h c=%b want v=1 00004581 @0 c=1", obs_valid, obs_inst, obs_pc, obs_c); end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_valid !== 1'b1 || obs_inst !== 32'h00004501 || obs_pc !== 32'h2 || obs_c !== 1'b1) begin
            n_fail++; $display("FAIL comp_second got v=%b %h @%h c=%b want v=1 00004501 @2 c=1", obs_valid, obs_inst, obs_pc, obs_c); end
    endtask

    task automatic test_straddle();
        logic got, last_mv;
        mem_img[0] = 32'h00934505; mem_img[1] = 32'h5A5A00A0; mem_delay = 3;
        do_reset();
        got = 1'b0; last_mv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_valid) begin got = 1'b1; break; end
        end
        n_tests++; if (got !== 1'b1 || obs_inst !== 32'h00004505 || obs_pc !== 32'h0 || obs_c !== 1'b1) begin
            n_fail++; $display("FAIL straddle_c got v=%b %h @%h c=%b want v=1 00004505 @0 c=1", got, obs_inst, obs_pc, obs_c); end
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_valid) begin got = 1'b1; break; end
            last_mv = obs_mvalid;
        end
        n_tests++; if (got !== 1'b1 || last_mv !== 1'b1) begin
            n_fail++; $display("FAIL straddle_timing got valid=%b prev_resp=%b want 1 1", got, last_mv); end
        n_tests++; if (obs_inst !== 32'h00A00093 || obs_pc !== 32'h2 || obs_c !== 1'b0) begin
            n_fail++; $display("FAIL straddle_inst got %h @%h c=%b want 00a00093 @2 c=0", obs_inst, obs_pc, obs_c); end
    endtask

    task automatic test_flush();
        logic stale_done, early, seen_req, got;
        logic [31:0] first_addr;
        mem_img[0] = 32'h0000_0013; mem_img[64] = 32'h4501_4581; mem_delay = 3;
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0102, 1'b1);
        stale_done = 1'b0; early = 1'b0; seen_req = 1'b0; got = 1'b0; first_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_after got %b want 0", obs_valid); end
            end
            if (obs_req && !stale_done) early = 1'b1;
            if (obs_req && !seen_req) begin seen_req = 1'b1; first_addr = obs_addr; end
            if (obs_mvalid) stale_done = 1'b1;
            if (obs_valid) begin got = 1'b1; break; end
        end
        n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL flush_drain_req got %b want 0", early); end
        n_tests++; if (first_addr !== 32'h100) begin n_fail++; $display("FAIL flush_req_addr got %h want 00000100", first_addr); end
        n_tests++; if (got !== 1'b1 || obs_pc !== 32'h102 || obs_inst !== 32'h00004501 || obs_c !== 1'b1) begin
            n_fail++; $display("FAIL flush_first got v=%b %h @%h c=%b want v=1 00004501 @102 c=1", got, obs_inst, obs_pc, obs_c); end
    endtask

    task automatic test_stall();
        mem_img[0] = 32'h8082_1234; mem_img[1] = 32'h0001_4505; mem_delay = 1;
        do_reset();
        step(1'b1, 1'b1, 32'h2, 1'b0);
        n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL stall_flush_req got %b want 0", obs_req); end
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL stall_req cyc%0d got %b want 0", i, obs_req); end
            n_tests++; if (obs_valid !== 1'b1 || obs_inst !== 32'h00008082 || obs_pc !== 32'h2) begin
                n_fail++; $display("FAIL stall_hold cyc%0d got v=%b %h @%h want v=1 00008082 @2", i, obs_valid, obs_inst, obs_pc); end
        end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_inst !== 32'h00004505 || obs_pc !== 32'h4 || obs_c !== 1'b1) begin
            n_fail++; $display("FAIL stall_next got %h @%h c=%b want 00004505 @4 c=1", obs_inst, obs_pc, obs_c); end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_valid !== 1'b1 || obs_inst !== 32'h00000001 || obs_pc !== 32'h6) begin
            n_fail++; $display("FAIL stall_third got v=%b %h @%h want v=1 00000001 @6", obs_valid, obs_inst, obs_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] reqs [2];
        logic [31:0] pcs [3];
        logic [31:0] insts [3];
        int nr, nv;
        mem_img[255] = 32'h0001_0001; mem_img[0] = 32'h4581_4505; mem_delay = 1;
        do_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        nr = 0; nv = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_req && nr < 2) begin reqs[nr] = obs_addr; nr++; end
            if (obs_valid && nv < 3) begin pcs[nv] = obs_pc; insts[nv] = obs_inst; nv++; end
            if (nv == 3) break;
        end
        n_tests++; if (nr != 2 || nv != 3) begin n_fail++; $display("FAIL wrap_progress got req=%0d inst=%0d want 2 3", nr, nv); end
        else begin
            n_tests++; if (reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) begin
                n_fail++; $display("FAIL wrap_addr got %h %h want fffffffc 00000000", reqs[0], reqs[1]); end
            n_tests++; if (pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'hFFFF_FFFE || pcs[2] !== 32'h0) begin
                n_fail++; $display("FAIL wrap_pc got %h %h %h want fffffffc fffffffe 00000000", pcs[0], pcs[1], pcs[2]); end
            n_tests++; if (insts[2] !== 32'h00004505) begin n_fail++; $display("FAIL wrap_inst got %h want 00004505", insts[2]); end
        end
    endtask

    task automatic test_reset_mid();
        logic got;
        mem_img[0] = 32'h45014581; mem_img[1] = 32'h0000_0013; mem_delay = 3;
        do_reset();
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        n_tests++; if (inst_valid_out !== 1'b1 || pc_out !== 32'h2) begin
            n_fail++; $display("FAIL rstmid_pre got v=%b @%h want v=1 @2", inst_valid_out, pc_out); end
        #1;
        rst_in = 1'b0;
        #1;
        n_tests++; if (inst_valid_out !== 1'b0 || inst_out !== 32'h0 || is_c_out !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async got v=%b %h c=%b want 0 0 0", inst_valid_out, inst_out, is_c_out); end
        n_tests++; if (pc_out !== 32'h0 || mem_req_out !== 1'b0 || mem_addr_out !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_async_pc got pc=%h req=%b addr=%h want 0 0 0", pc_out, mem_req_out, mem_addr_out); end
        pend_wait = 0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_restart got req=%b addr=%h want 1 0", obs_req, obs_addr); end
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_valid) begin got = 1'b1; break; end
        end
        n_tests++; if (got !== 1'b1 || obs_pc !== 32'h0 || obs_inst !== 32'h00004581 || obs_c !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_first got v=%b %h @%h c=%b want v=1 00004581 @0 c=1", got, obs_inst, obs_pc, obs_c); end
    endtask

    task automatic test_random();
        logic        rdy, fl, rdyi, prev_flush, exp_c;
        logic [31:0] fpc, exp_pc, exp_inst;
        logic [15:0] lo;
        int          accepted;
        for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
        rand_delay = 1'b1;
        do_reset();
        exp_pc = 32'h0; accepted = 0; prev_flush = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy  = ($urandom_range(0, 99) < 85);
            fl   = ($urandom_range(0, 99) < 3);
            rdyi = ($urandom_range(0, 99) < 70);
            fpc  = 32'($urandom_range(0, 511)) << 1;
            step(rdy, fl, fpc, rdyi);
            if (prev_flush) begin
                n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rand_flush_valid cyc%0d got %b want 0", cyc, obs_valid); end
            end
            if (obs_req) begin
                n_tests++; if (obs_req_busy !== 1'b0 || obs_addr[1:0] !== 2'b00) begin
                    n_fail++; $display("FAIL rand_req cyc%0d busy=%b addr=%h want 0 aligned", cyc, obs_req_busy, obs_addr); end
            end
            if (rdy && !fl && obs_valid && rdyi) begin
                lo = hw_at(exp_pc);
                if (lo[1:0] != 2'b11) begin
                    exp_inst = {16'h0, lo}; exp_c = 1'b1;
                end else begin
                    exp_inst = {hw_at(exp_pc + 32'd2), lo}; exp_c = 1'b0;
                end
                n_tests++; if (obs_inst !== exp_inst || obs_pc !== exp_pc || obs_c !== exp_c) begin
                    n_fail++; $display("FAIL rand_inst cyc%0d got %h @%h c=%b want %h @%h c=%b", cyc, obs_inst, obs_pc, obs_c, exp_inst, exp_pc, exp_c); end
                exp_pc = exp_pc + (exp_c ? 32'd2 : 32'd4);
                accepted++;
            end
            if (rdy && fl) exp_pc = fpc;
            prev_flush = rdy && fl;
        end
        n_tests++; if (accepted < 300) begin n_fail++; $display("FAIL rand_progress got %0d want >=300", accepted); end
        rand_delay = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_compressed();
        test_straddle();
        test_flush();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
